// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks each instruction through fetch..writeback,
// owns the PC and retire counter, and traps into FAULT when a stage stalls too long.
module stage_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned STALL_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    output logic [4:0]  stage_ready,
    input  logic [4:0]  stage_done,
    input  logic        cond_pass,
    input  logic        skip_mem,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] pc,
    output logic [7:0]  instruction_stage,
    output logic [31:0] inst_count,
    output logic        fault
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_FAULT
    } state_t;

    localparam logic [7:0] LIMIT = 8'(STALL_TIMEOUT);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg;
    logic [31:0] count_reg;
    logic        br_reg;
    logic [31:0] tgt_reg;
    logic [7:0]  wdog_reg;

    logic        retire;
    logic        ex_done;
    logic        in_stage;
    logic        active_done;

    always_comb begin
        state_next        = state_reg;
        retire            = 1'b0;
        ex_done           = 1'b0;
        in_stage          = 1'b0;
        active_done       = 1'b0;
        stage_ready       = 5'b00000;
        instruction_stage = 8'h00;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                stage_ready       = 5'b00001;
                instruction_stage = 8'h01;
                in_stage          = 1'b1;
                active_done       = stage_done[0];
                if (active_done) state_next = S_DECODE;
            end
            S_DECODE: begin
                stage_ready       = 5'b00010;
                instruction_stage = 8'h02;
                in_stage          = 1'b1;
                active_done       = stage_done[1];
                if (active_done) state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                stage_ready       = 5'b00100;
                instruction_stage = 8'h03;
                in_stage          = 1'b1;
                active_done       = stage_done[2];
                if (active_done) begin
                    ex_done = 1'b1;
                    // A failed condition retires here as an annulled instruction.
                    if (!cond_pass) begin
                        retire     = 1'b1;
                        state_next = run ? S_FETCH : S_IDLE;
                    end else if (skip_mem) begin
                        state_next = S_WRITEBACK;
                    end else begin
                        state_next = S_MEMORY;
                    end
                end
            end
            S_MEMORY: begin
                stage_ready       = 5'b01000;
                instruction_stage = 8'h04;
                in_stage          = 1'b1;
                active_done       = stage_done[3];
                if (active_done) state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                stage_ready       = 5'b10000;
                instruction_stage = 8'h05;
                in_stage          = 1'b1;
                active_done       = stage_done[4];
                if (active_done) begin
                    retire     = 1'b1;
                    state_next = run ? S_FETCH : S_IDLE;
                end
            end
            S_FAULT: begin
                instruction_stage = 8'hFF;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Done arriving in the limit cycle still wins over the watchdog.
        if (in_stage && !active_done && wdog_reg == LIMIT)
            state_next = S_FAULT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= RESET_PC;
            count_reg <= 32'd0;
            br_reg    <= 1'b0;
            tgt_reg   <= 32'd0;
            wdog_reg  <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_next != state_reg)
                wdog_reg <= 8'd0;
            else if (in_stage && !active_done)
                wdog_reg <= wdog_reg + 8'd1;
            if (retire) begin
                // Only a writeback retire can carry a taken branch.
                pc_reg    <= (state_reg == S_WRITEBACK && br_reg) ? tgt_reg : pc_reg + 32'd4;
                count_reg <= count_reg + 32'd1;
                br_reg    <= 1'b0;
            end else if (ex_done) begin
                br_reg  <= branch_taken & cond_pass;
                tgt_reg <= branch_target & ~32'h0000_0003;
            end
        end
    end

    assign pc         = pc_reg;
    assign inst_count = count_reg;
    assign fault      = (state_reg == S_FAULT);
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: sequencing, branch, annul, skip_mem,
// run drop, watchdog, reset-PC wrap and asynchronous reset.
module tb_stage_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        reset2;
    logic        run;
    logic [4:0]  stage_done;
    logic        cond_pass;
    logic        skip_mem;
    logic        branch_taken;
    logic [31:0] branch_target;

    logic [4:0]  stage_ready, stage_ready2;
    logic [31:0] pc, pc2;
    logic [7:0]  instruction_stage, instruction_stage2;
    logic [31:0] inst_count, inst_count2;
    logic        fault, fault2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    stage_sequencer #(.RESET_PC(32'h0000_0000), .STALL_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .run(run), .stage_ready(stage_ready),
        .stage_done(stage_done), .cond_pass(cond_pass), .skip_mem(skip_mem),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
        .instruction_stage(instruction_stage), .inst_count(inst_count), .fault(fault)
    );

    stage_sequencer #(.RESET_PC(32'hFFFF_FFFC), .STALL_TIMEOUT(15)) dut_wrap (
        .clk(clk), .reset(reset2), .run(run), .stage_ready(stage_ready2),
        .stage_done(stage_done), .cond_pass(cond_pass), .skip_mem(skip_mem),
        .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc2),
        .instruction_stage(instruction_stage2), .inst_count(inst_count2), .fault(fault2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
        $display("check %-16s observed %h expected %h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; reset2 = 1'b1; run = 1'b0; stage_done = 5'b00000;
        cond_pass = 1'b1; skip_mem = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        tick();
        check("rst_ready", {27'd0, stage_ready}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_count", inst_count, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_stage", {24'd0, instruction_stage}, 32'h00);
        tick();
        reset = 1'b0; run = 1'b1; stage_done = 5'b11111;

        // Two full instructions, single-cycle stages
        for (int i = 0; i < 2; i++) begin
            for (int s = 0; s < 5; s++) begin
                tick();
                check("seq_ready", {27'd0, stage_ready}, 32'd1 << s);
                check("seq_stage", {24'd0, instruction_stage}, 32'(s + 1));
                check("seq_pc", pc, 32'(4 * i));
                check("seq_count", inst_count, 32'(i));
            end
        end
        tick();
        check("seq3_ready", {27'd0, stage_ready}, 32'h01);
        check("seq3_pc", pc, 32'h8);
        check("seq3_count", inst_count, 32'd2);

        // Taken branch with unaligned target
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0103;
        tick();
        check("br_ex", {27'd0, stage_ready}, 32'h04);
        tick();
        branch_taken = 1'b0; branch_target = 32'h0;
        check("br_mem", {27'd0, stage_ready}, 32'h08);
        check("br_pc_hold", pc, 32'h8);
        tick();
        check("br_wb", {27'd0, stage_ready}, 32'h10);
        tick();
        check("br_fetch", {27'd0, stage_ready}, 32'h01);
        check("br_pc", pc, 32'h100);
        check("br_count", inst_count, 32'd3);

        // Annulled branch: three-cycle instruction, pc+4
        tick();
        branch_taken = 1'b1; branch_target = 32'h0000_0200; cond_pass = 1'b0;
        tick();
        check("ann_ex", {27'd0, stage_ready}, 32'h04);
        tick();
        check("ann_fetch", {27'd0, stage_ready}, 32'h01);
        check("ann_pc", pc, 32'h104);
        check("ann_count", inst_count, 32'd4);
        cond_pass = 1'b1; branch_taken = 1'b0; branch_target = 32'h0;

        // skip_mem: execute straight to writeback
        skip_mem = 1'b1;
        tick();
        tick();
        check("skip_ex", {27'd0, stage_ready}, 32'h04);
        tick();
        check("skip_wb", {27'd0, stage_ready}, 32'h10);
        tick();
        skip_mem = 1'b0;
        check("skip_fetch", {27'd0, stage_ready}, 32'h01);
        check("skip_pc", pc, 32'h108);
        check("skip_count", inst_count, 32'd5);

        // Drop run in decode: instruction completes, then IDLE
        tick();
        run = 1'b0;
        check("drop_dec", {27'd0, stage_ready}, 32'h02);
        tick(); tick(); tick();
        check("drop_wb", {27'd0, stage_ready}, 32'h10);
        tick();
        check("idle_ready", {27'd0, stage_ready}, 32'h00);
        check("idle_stage", {24'd0, instruction_stage}, 32'h00);
        check("idle_pc", pc, 32'h10C);
        check("idle_count", inst_count, 32'd6);
        tick();
        check("idle_stay", {27'd0, stage_ready}, 32'h00);

        // Watchdog: execute done held low -> fault after 16 execute cycles
        run = 1'b1; stage_done = 5'b11011;
        tick(); tick(); tick();
        check("wd_ex1", {27'd0, stage_ready}, 32'h04);
        for (int k = 0; k < 15; k++) begin
            tick();
            check("wd_hold", {27'd0, stage_ready}, 32'h04);
            check("wd_nofault", {31'd0, fault}, 32'd0);
        end
        tick();
        check("wd_fault", {31'd0, fault}, 32'd1);
        check("wd_stage", {24'd0, instruction_stage}, 32'hFF);
        check("wd_ready", {27'd0, stage_ready}, 32'h00);
        check("wd_pc", pc, 32'h10C);
        check("wd_count", inst_count, 32'd6);
        stage_done = 5'b11111;
        tick(); tick();
        check("wd_sticky", {31'd0, fault}, 32'd1);
        check("wd_pc_frz", pc, 32'h10C);

        // Reset clears fault; done in the limit cycle avoids fault
        #2 reset = 1'b1;
        #1;
        check("rst2_fault", {31'd0, fault}, 32'd0);
        check("rst2_pc", pc, 32'h0);
        reset = 1'b0; stage_done = 5'b11011;
        tick(); tick(); tick();
        check("lim_ex1", {27'd0, stage_ready}, 32'h04);
        for (int k = 0; k < 15; k++) tick();
        check("lim_last", {27'd0, stage_ready}, 32'h04);
        stage_done = 5'b11111;
        tick();
        check("lim_mem", {27'd0, stage_ready}, 32'h08);
        check("lim_nofault", {31'd0, fault}, 32'd0);
        tick(); tick();
        check("lim_pc", pc, 32'h4);
        check("lim_count", inst_count, 32'd1);

        // Asynchronous reset mid-memory
        tick(); tick(); tick();
        check("arst_mem", {27'd0, stage_ready}, 32'h08);
        reset = 1'b1;
        #1;
        check("arst_ready", {27'd0, stage_ready}, 32'h00);
        check("arst_pc", pc, 32'h0);
        check("arst_count", inst_count, 32'd0);
        check("arst_stage", {24'd0, instruction_stage}, 32'h00);
        reset = 1'b0;
        tick();
        check("arst_fetch", {27'd0, stage_ready}, 32'h01);
        check("arst_pc0", pc, 32'h0);

        // PC wrap from 32'hFFFF_FFFC
        check("wrap_rst_pc", pc2, 32'hFFFF_FFFC);
        reset2 = 1'b0;
        for (int s = 0; s < 5; s++) tick();
        check("wrap_wb", {27'd0, stage_ready2}, 32'h10);
        tick();
        check("wrap_pc", pc2, 32'h0);
        check("wrap_count", inst_count2, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
